mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MIPS pipeline memory stage; consumer end of the execute→memory interface.
- Accepts e_m_reg_t from execute under a valid/ready handshake.
- Performs word loads and stores on a single-outstanding data bus.
- Delivers m_w_reg_t to writeback; stalls execute while a memory access is outstanding.

Parameters:
- STORE_STRB, 4'b1111, byte strobe driven for SW (word-only ISA subset).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- e_m_valid  in  1  e_m_reg holds a real instruction.
- e_m_reg  in  e_m_reg_t  execute outputs: mem_to_reg, mem_write, reg_write, reg_dst, alu_result, rt_word, rs, rt, rd, pc, pc_plus_4, instruction.
- e_m_ready  out  1  stage can accept this cycle.
- dreq_valid  out  1  data-bus request active.
- dreq_addr  out  32  byte address.
- dreq_strobe  out  4  write byte enables; 0 for a load.
- dreq_data  out  32  store data.
- dresp_data_ok  in  1  access complete; load data valid.
- dresp_data  in  32  load data.
- m_w_reg  out  m_w_reg_t  valid, reg_write, write_reg[4:0], result[31:0], pc, instruction.

Behaviour:
- FSM states: IDLE, MEM. Reset forces IDLE asynchronously, clears the held op and drives m_w_reg to all-zero (valid=0, reg_write=0).
- Ready rule: e_m_ready = (state==IDLE). Accept = e_m_valid & e_m_ready.
- IDLE, accept of a non-memory op (mem_to_reg=0, mem_write=0):
  - At the edge, load m_w_reg: valid=1, reg_write from input, result=alu_result.
  - write_reg = reg_dst ? rd : rt.
  - Stay in IDLE. Latency 1 cycle.
- IDLE, accept of a load or store:
  - At the edge, latch the op into the held register and go to MEM.
  - m_w_reg.valid=0 at that edge.
- IDLE, no accept: m_w_reg.valid=0 at the edge (bubble).
- MEM:
  - Drive dreq_valid=1 and dreq_addr=held alu_result.
  - Load: strobe=0. Store: strobe=STORE_STRB, data=held rt_word.
  - All dreq_* are stable until dresp_data_ok.
  - When dresp_data_ok=1: at the edge, load m_w_reg with valid=1, result=dresp_data for a load (alu_result for a store), reg_write=0 for a store. Return to IDLE.
  - The next op can be accepted in the following cycle. Minimum memory latency is 2 cycles.
- dresp_data_ok is ignored in IDLE.
- dreq_valid is 0 in IDLE and immediately (combinationally) 0 on reset assertion.
- Reset mid-access: the access is abandoned and no m_w_reg is produced. Any later dresp_data_ok is ignored.
- Writeback never back-pressures. m_w_reg is a register and holds for exactly one cycle per completed op.
- Address arithmetic: none. Only the low 2 bits are inspected (see Optional Feature).

Optional Feature:
- MEM_MISALIGN_CHECK_EN defined:
  - A load/store with alu_result[1:0]≠0 does not enter MEM and issues no bus request.
  - At the accept edge, m_w_reg gets valid=1, reg_write=0, result=alu_result, and exc=2'b01 (load) or 2'b10 (store).
- Macro undefined:
  - No exc field is present.
  - dreq_addr[1:0] is forced to 2'b00.
  - A misaligned access proceeds as an aligned word access.

Decomposition:
- Package pipes:
  - Add rt_word to e_m_reg_t.
  - Define m_w_reg_t.
  - Add mem_state_t enum {IDLE, MEM}.
  - Under the macro, add the exc encoding constants.
- Package common: u32, u5.
- Natural sub-module: mem_req_gen. Combinational; maps the held op plus state to dreq_valid/addr/strobe/data.

Test Plan:
- ADDI: reg_dst=0, rt=5, alu_result=0x10, valid 1 cycle → next edge m_w_reg{valid=1, write_reg=5, result=0x10}; e_m_ready stays 1.
- LW: alu_result=0x100, rt=8, dresp_data_ok after 3 cycles with data 0xDEADBEEF → dreq_valid=1, addr=0x100, strobe=0 held 3 cycles; e_m_ready=0 throughout; m_w_reg{valid=1, write_reg=8, result=0xDEADBEEF}.
- SW: alu_result=0x204, rt_word=0x1234 → dreq addr=0x204, strobe=4'hF, data=0x1234; on data_ok, m_w_reg valid=1 with reg_write=0.
- Back-to-back: LW followed by ADD held at e_m_valid → ADD accepted in the cycle after data_ok; two m_w_reg valids in order, no loss or duplication.
- reset_n pulsed low while in MEM → dreq_valid drops immediately; state IDLE, m_w_reg.valid=0; a stray data_ok afterwards produces no output.
- With MEM_MISALIGN_CHECK_EN, LW to 0x102 → no dreq_valid; next edge m_w_reg{valid=1, reg_write=0, exc=2'b01}. Without the macro, dreq_addr=0x100.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared scalar types and pipeline bundles for the memory stage.
// MEM_MISALIGN_CHECK_EN adds the exc field and its encodings.
package common;
    typedef logic [31:0] u32;
    typedef logic [4:0]  u5;
endpackage

package pipes;
    import common::*;

    typedef struct packed {
        logic mem_to_reg;
        logic mem_write;
        logic reg_write;
        logic reg_dst;
        u32   alu_result;
        u32   rt_word;
        u5    rs;
        u5    rt;
        u5    rd;
        u32   pc;
        u32   pc_plus_4;
        u32   instruction;
    } e_m_reg_t;

    typedef struct packed {
        logic       valid;
        logic       reg_write;
        u5          write_reg;
        u32         result;
        u32         pc;
        u32         instruction;
`ifdef MEM_MISALIGN_CHECK_EN
        logic [1:0] exc;
`endif
    } m_w_reg_t;

    typedef enum logic {
        IDLE = 1'b0,
        MEM  = 1'b1
    } mem_state_t;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam logic [1:0] EXC_NONE      = 2'b00;
    localparam logic [1:0] EXC_LOAD_MIS  = 2'b01;
    localparam logic [1:0] EXC_STORE_MIS = 2'b10;
`endif

    function automatic u5 wreg_sel(input e_m_reg_t op);
        return op.reg_dst ? op.rd : op.rt;
    endfunction
endpackage

// File: rtl/mem_stage_req_gen.sv
// Combinational data-bus request generator for the memory stage.
// Without MEM_MISALIGN_CHECK_EN the word address is forced aligned.
module mem_req_gen
    import common::*;
#(
    parameter logic [3:0] STORE_STRB = 4'b1111
) (
    input  logic       i_busy,
    input  logic       i_mem_write,
    input  u32         i_addr,
    input  u32         i_data,
    output logic       o_valid,
    output u32         o_addr,
    output logic [3:0] o_strobe,
    output u32         o_data
);
    always_comb begin
        o_valid  = i_busy;
        o_addr   = '0;
        o_strobe = '0;
        o_data   = '0;
        if (i_busy) begin
`ifdef MEM_MISALIGN_CHECK_EN
            o_addr = i_addr;
`else
            o_addr = {i_addr[31:2], 2'b00};
`endif
            if (i_mem_write) begin
                o_strobe = STORE_STRB;
                o_data   = i_data;
            end
        end
    end
endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: single-outstanding word loads/stores.
// MEM_MISALIGN_CHECK_EN traps misaligned accesses at accept.
module mem_stage
    import common::*;
    import pipes::*;
#(
    parameter logic [3:0] STORE_STRB = 4'b1111
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       e_m_valid,
    input  e_m_reg_t   e_m_reg,
    output logic       e_m_ready,
    output logic       dreq_valid,
    output u32         dreq_addr,
    output logic [3:0] dreq_strobe,
    output u32         dreq_data,
    input  logic       dresp_data_ok,
    input  u32         dresp_data,
    output m_w_reg_t   m_w_reg
);
    mem_state_t r_state;
    mem_state_t w_next;
    e_m_reg_t   r_held;
    m_w_reg_t   r_mw;
    m_w_reg_t   w_mw;
    logic       w_accept;
    logic       w_is_mem;
    logic       w_mis;
    logic       w_load;
    logic       w_unused;

    assign w_unused = ^{e_m_reg.rs, e_m_reg.pc_plus_4,
                        r_held.rs, r_held.pc_plus_4};

    assign e_m_ready = (r_state == IDLE);
    assign w_accept  = e_m_valid & e_m_ready;
    assign w_is_mem  = e_m_reg.mem_to_reg | e_m_reg.mem_write;
`ifdef MEM_MISALIGN_CHECK_EN
    assign w_mis = w_is_mem & (|e_m_reg.alu_result[1:0]);
`else
    assign w_mis = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_held  <= '0;
            r_mw    <= '0;
        end else begin
            r_state <= w_next;
            r_mw    <= w_mw;
            if (w_load)
                r_held <= e_m_reg;
        end
    end

    always_comb begin
        w_next = r_state;
        w_mw   = '0;
        w_load = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_mw.pc          = e_m_reg.pc;
                    w_mw.instruction = e_m_reg.instruction;
                    w_mw.write_reg   = wreg_sel(e_m_reg);
                    w_mw.result      = e_m_reg.alu_result;
                    if (w_is_mem && !w_mis) begin
                        w_mw   = '0;
                        w_load = 1'b1;
                        w_next = MEM;
                    end else if (w_is_mem) begin
`ifdef MEM_MISALIGN_CHECK_EN
                        w_mw.valid = 1'b1;
                        w_mw.exc   = e_m_reg.mem_write ?
                                     EXC_STORE_MIS : EXC_LOAD_MIS;
`endif
                    end else begin
                        w_mw.valid     = 1'b1;
                        w_mw.reg_write = e_m_reg.reg_write;
                    end
                end
            end
            MEM: begin
                if (dresp_data_ok) begin
                    w_mw.valid       = 1'b1;
                    w_mw.reg_write   = r_held.reg_write &
                                       ~r_held.mem_write;
                    w_mw.write_reg   = wreg_sel(r_held);
                    w_mw.result      = r_held.mem_to_reg ?
                                       dresp_data : r_held.alu_result;
                    w_mw.pc          = r_held.pc;
                    w_mw.instruction = r_held.instruction;
                    w_next           = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign m_w_reg = r_mw;

    mem_req_gen #(
        .STORE_STRB (STORE_STRB)
    ) u_req (
        .i_busy      (r_state == MEM),
        .i_mem_write (r_held.mem_write),
        .i_addr      (r_held.alu_result),
        .i_data      (r_held.rt_word),
        .o_valid     (dreq_valid),
        .o_addr      (dreq_addr),
        .o_strobe    (dreq_strobe),
        .o_data      (dreq_data)
    );
endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
// Honours MEM_MISALIGN_CHECK_EN when defined.
module tb_mem_stage;
    import common::*;
    import pipes::*;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       e_m_valid;
    e_m_reg_t   e_m_reg;
    logic       e_m_ready;
    logic       dreq_valid;
    u32         dreq_addr;
    logic [3:0] dreq_strobe;
    u32         dreq_data;
    logic       dresp_data_ok;
    u32         dresp_data;
    m_w_reg_t   m_w_reg;

    int n_vec = 0;
    int n_err = 0;

    mem_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .e_m_valid     (e_m_valid),
        .e_m_reg       (e_m_reg),
        .e_m_ready     (e_m_ready),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_strobe   (dreq_strobe),
        .dreq_data     (dreq_data),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .m_w_reg       (m_w_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input u32 got, input u32 exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic e_m_reg_t mk(input logic mtr, input logic mw,
                                    input logic rw, input logic rdst,
                                    input u32 alu, input u32 rtw,
                                    input u5 rt, input u5 rd);
        e_m_reg_t op;
        op             = '0;
        op.mem_to_reg  = mtr;
        op.mem_write   = mw;
        op.reg_write   = rw;
        op.reg_dst     = rdst;
        op.alu_result  = alu;
        op.rt_word     = rtw;
        op.rt          = rt;
        op.rd          = rd;
        op.pc          = 32'h0040_0000 + alu;
        op.instruction = 32'h1000_0000 | alu;
        return op;
    endfunction

    initial begin
        reset_n       = 1'b0;
        e_m_valid     = 1'b0;
        e_m_reg       = '0;
        dresp_data_ok = 1'b0;
        dresp_data    = '0;
        tick();
        tick();
        chk("rst_valid", 32'(m_w_reg.valid), 32'd0);
        chk("rst_ready", 32'(e_m_ready), 32'd1);
        chk("rst_dreq", 32'(dreq_valid), 32'd0);
        reset_n = 1'b1;
        tick();

        // ADDI
        e_m_valid = 1'b1;
        e_m_reg   = mk(0, 0, 1, 0, 32'h10, 32'h0, 5'd5, 5'd0);
        chk("addi_ready", 32'(e_m_ready), 32'd1);
        tick();
        e_m_valid = 1'b0;
        chk("addi_valid", 32'(m_w_reg.valid), 32'd1);
        chk("addi_wreg", 32'(m_w_reg.write_reg), 32'd5);
        chk("addi_res", m_w_reg.result, 32'h10);
        chk("addi_rw", 32'(m_w_reg.reg_write), 32'd1);
        chk("addi_pc", m_w_reg.pc, 32'h0040_0010);
        chk("addi_ready2", 32'(e_m_ready), 32'd1);
        chk("addi_nodreq", 32'(dreq_valid), 32'd0);
        tick();
        chk("addi_once", 32'(m_w_reg.valid), 32'd0);

        // LW, data_ok in third MEM cycle
        e_m_valid = 1'b1;
        e_m_reg   = mk(1, 0, 1, 0, 32'h100, 32'h0, 5'd8, 5'd0);
        tick();
        e_m_valid = 1'b0;
        chk("lw_bubble", 32'(m_w_reg.valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("lw_dreq", 32'(dreq_valid), 32'd1);
            chk("lw_addr", dreq_addr, 32'h100);
            chk("lw_strb", 32'(dreq_strobe), 32'd0);
            chk("lw_ready", 32'(e_m_ready), 32'd0);
            if (i == 2) begin
                dresp_data_ok = 1'b1;
                dresp_data    = 32'hDEAD_BEEF;
            end else begin
                chk("lw_wait", 32'(m_w_reg.valid), 32'd0);
            end
            tick();
        end
        dresp_data_ok = 1'b0;
        chk("lw_valid", 32'(m_w_reg.valid), 32'd1);
        chk("lw_wreg", 32'(m_w_reg.write_reg), 32'd8);
        chk("lw_res", m_w_reg.result, 32'hDEAD_BEEF);
        chk("lw_rw", 32'(m_w_reg.reg_write), 32'd1);
        chk("lw_done_ready", 32'(e_m_ready), 32'd1);
        chk("lw_done_dreq", 32'(dreq_valid), 32'd0);

        // SW, minimum latency
        e_m_valid = 1'b1;
        e_m_reg   = mk(0, 1, 1, 0, 32'h204, 32'h1234, 5'd3, 5'd0);
        tick();
        e_m_valid = 1'b0;
        chk("sw_dreq", 32'(dreq_valid), 32'd1);
        chk("sw_addr", dreq_addr, 32'h204);
        chk("sw_strb", 32'(dreq_strobe), 32'hF);
        chk("sw_data", dreq_data, 32'h1234);
        dresp_data_ok = 1'b1;
        dresp_data    = 32'h5555_5555;
        tick();
        dresp_data_ok = 1'b0;
        chk("sw_valid", 32'(m_w_reg.valid), 32'd1);
        chk("sw_rw", 32'(m_w_reg.reg_write), 32'd0);
        chk("sw_res", m_w_reg.result, 32'h204);

        // LW then ADD held at e_m_valid
        e_m_valid = 1'b1;
        e_m_reg   = mk(1, 0, 1, 0, 32'h300, 32'h0, 5'd9, 5'd0);
        tick();
        e_m_reg = mk(0, 0, 1, 1, 32'h55, 32'h0, 5'd2, 5'd10);
        chk("b2b_ready0", 32'(e_m_ready), 32'd0);
        tick();
        chk("b2b_stall", 32'(m_w_reg.valid), 32'd0);
        dresp_data_ok = 1'b1;
        dresp_data    = 32'hCAFE_F00D;
        tick();
        dresp_data_ok = 1'b0;
        chk("b2b_lw_valid", 32'(m_w_reg.valid), 32'd1);
        chk("b2b_lw_res", m_w_reg.result, 32'hCAFE_F00D);
        chk("b2b_lw_wreg", 32'(m_w_reg.write_reg), 32'd9);
        chk("b2b_ready1", 32'(e_m_ready), 32'd1);
        tick();
        e_m_valid = 1'b0;
        chk("b2b_add_valid", 32'(m_w_reg.valid), 32'd1);
        chk("b2b_add_res", m_w_reg.result, 32'h55);
        chk("b2b_add_wreg", 32'(m_w_reg.write_reg), 32'd10);
        tick();
        chk("b2b_no_dup", 32'(m_w_reg.valid), 32'd0);

        // Reset mid-access
        e_m_valid = 1'b1;
        e_m_reg   = mk(1, 0, 1, 0, 32'h400, 32'h0, 5'd7, 5'd0);
        tick();
        e_m_valid = 1'b0;
        chk("rm_dreq", 32'(dreq_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rm_dreq_drop", 32'(dreq_valid), 32'd0);
        chk("rm_ready", 32'(e_m_ready), 32'd1);
        chk("rm_valid", 32'(m_w_reg.valid), 32'd0);
        tick();
        reset_n       = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = 32'h1111_2222;
        tick();
        dresp_data_ok = 1'b0;
        chk("rm_stray", 32'(m_w_reg.valid), 32'd0);
        chk("rm_stray_dreq", 32'(dreq_valid), 32'd0);
        tick();
        chk("rm_stray2", 32'(m_w_reg.valid), 32'd0);

        // Misaligned LW
        e_m_valid = 1'b1;
        e_m_reg   = mk(1, 0, 1, 0, 32'h102, 32'h0, 5'd4, 5'd0);
        tick();
        e_m_valid = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_nodreq", 32'(dreq_valid), 32'd0);
        chk("mis_valid", 32'(m_w_reg.valid), 32'd1);
        chk("mis_rw", 32'(m_w_reg.reg_write), 32'd0);
        chk("mis_exc", 32'(m_w_reg.exc), 32'd1);
        chk("mis_res", m_w_reg.result, 32'h102);
        chk("mis_ready", 32'(e_m_ready), 32'd1);
        e_m_valid = 1'b1;
        e_m_reg   = mk(0, 1, 0, 0, 32'h207, 32'h99, 5'd1, 5'd0);
        tick();
        e_m_valid = 1'b0;
        chk("mis_sw_nodreq", 32'(dreq_valid), 32'd0);
        chk("mis_sw_exc", 32'(m_w_reg.exc), 32'd2);
        chk("mis_sw_valid", 32'(m_w_reg.valid), 32'd1);
`else
        chk("mis_dreq", 32'(dreq_valid), 32'd1);
        chk("mis_addr", dreq_addr, 32'h100);
        chk("mis_wait", 32'(m_w_reg.valid), 32'd0);
        dresp_data_ok = 1'b1;
        dresp_data    = 32'h0000_0077;
        tick();
        dresp_data_ok = 1'b0;
        chk("mis_valid", 32'(m_w_reg.valid), 32'd1);
        chk("mis_res", m_w_reg.result, 32'h77);
        chk("mis_wreg", 32'(m_w_reg.write_reg), 32'd4);
`endif
        tick();
        chk("end_idle", 32'(m_w_reg.valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
